hamming_sec_stream_encoder: RTL and testbench
=============================================

Name: hamming_sec_stream_encoder

Overview:
- Parametrised, streaming Hamming SEC encoder; next generation of the team's fixed 8-bit combinational encoder.
- Accepts DATA_W-bit words on a valid/ready input and encodes each to a CODE_W-bit Hamming codeword.
- Buffers codewords in a 2-entry output queue with valid/ready backpressure.
- Sits between a write-data producer and the protected memory write port; keeps a saturating count of delivered codewords for status.

Parameters:
- DATA_W, 8, data word width; legal range 4..120.
- CNT_W, 16, width of the delivered-codeword counter.
- Derived (localparam): P = smallest r with 2^r >= DATA_W + r + 1; CODE_W = DATA_W + P (+1 when HAM_SECDED_EN defined). DATA_W=8 -> P=4, CODE_W=12; DATA_W=32 -> P=6, CODE_W=38.

Ports:
- clk  in  1  clock, all state rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  encoder can accept a word.
- in_data  in  DATA_W  data word.
- out_valid  out  1  codeword valid.
- out_ready  in  1  consumer accepts codeword.
- out_code  out  CODE_W  encoded codeword.
- cnt_clr  in  1  synchronous clear of word_cnt.
- word_cnt  out  CNT_W  saturating count of output handshakes.

Behaviour:
- Code layout: code index i is Hamming position p = i+1. Parity bits sit at p = 1,2,4,...,2^(P-1) (indices 0,1,3,7,...).
- Data bits fill the remaining positions in ascending order, in_data[0] at the lowest.
- Parity bit k = XOR of all data positions p with bit k of p set.
- DATA_W=8 result: data at indices 2,4,5,6,8,9,10,11; parity at 0,1,3,7.
- Encoding is combinational on in_data; the result is written into the queue on input handshake (in_valid & in_ready).
- Queue: 2 entries, FIFO order, occupancy cnt in {0,1,2}.
  - in_ready = (cnt != 2).
  - out_valid = (cnt != 0).
  - out_code = head entry.
- Latency: word accepted at edge N is presented on out_code after edge N (one cycle) when the queue was empty.
- Throughput: 1 word/cycle while out_ready stays high.
- Simultaneous push and pop:
  - cnt=1: cnt stays 1; head replaced by the new word.
  - cnt=0: no pop possible; push only.
  - cnt=2: push blocked by in_ready=0; pop only.
- out_code and out_valid hold stable while out_valid & !out_ready.
- Data presented while in_ready=0 is ignored, not captured.
- word_cnt:
  - Increments on output handshake (out_valid & out_ready).
  - Saturates at all-ones.
  - cnt_clr has priority: the same-cycle handshake is not counted and word_cnt becomes 0.
- Reset (any time, including mid-transfer): cnt=0, out_valid=0, in_ready=1, out_code=0, word_cnt=0; queued words are discarded.
- Entries are not cleared on pop; out_code shows the stale head when out_valid=0. Consumers qualify with out_valid.

Optional Feature:
- Macro HAM_SECDED_EN.
- Defined: CODE_W = DATA_W + P + 1. out_code[CODE_W-1] = XOR of all lower CODE_W-1 bits (even overall parity, SECDED). Lower bits are identical to the SEC code.
- Undefined: pure SEC; CODE_W = DATA_W + P; no overall parity bit.

Test Plan:
- DATA_W=8, out_ready=1, single words 0x00, 0x01, 0x80, 0xFF -> out_code 0x000, 0x007, 0x888, 0xF77, each one cycle after accept; word_cnt=4.
- HAM_SECDED_EN, DATA_W=8: 0x01 -> 0x1007; 0xFF -> 0x0F77 (13 bits).
- Backpressure: out_ready=0, push 0x11, 0x22 back-to-back -> in_ready drops after the second accept; third word 0x33 held, not captured. Release out_ready -> codewords of 0x11, 0x22, then 0x33 delivered in order, none lost.
- Streaming at cnt=1 with in_valid=out_ready=1 for 100 cycles of random data -> 100 codewords, each matching the reference model; in_ready never low.
- Counter: CNT_W=4, 20 handshakes -> word_cnt saturates at 15; cnt_clr pulsed during a handshake -> word_cnt=0 next cycle.
- Reset: assert rst_n=0 asynchronously with cnt=2 -> out_valid=0, in_ready=1, word_cnt=0 immediately; after release, the first accepted word emerges correctly.
- Widths: DATA_W=4, 32, 64 random sweep -> out_code matches the parity model; CODE_W = 7, 38, 71.

Source files
------------

// File: rtl/hamming_sec_stream_encoder.sv
// Streaming Hamming SEC encoder with a 2-entry output queue and a saturating delivered-word counter.
// Define HAM_SECDED_EN to append an even overall-parity bit (SECDED) above the SEC codeword.
module hamming_sec_stream_encoder #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16,
  localparam int P = (DATA_W <= 4)  ? 3 :
                     (DATA_W <= 11) ? 4 :
                     (DATA_W <= 26) ? 5 :
                     (DATA_W <= 57) ? 6 : 7,
`ifdef HAM_SECDED_EN
  localparam int CODE_W = DATA_W + P + 1
`else
  localparam int CODE_W = DATA_W + P
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  word_cnt
);

  localparam int unsigned SEC_W = DATA_W + P;
  localparam int unsigned PU    = P;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } occ_t;

  occ_t              occ, occ_nxt;
  logic [SEC_W-1:0]  placed;
  logic [SEC_W-1:0]  sec;
  logic [P-1:0]      par;
  logic [CODE_W-1:0] enc;
  logic [CODE_W-1:0] q0, q1;
  logic              push, pop;

  // Data bits go to every non-power-of-two position p = i+1, LSB first.
  always_comb begin
    int unsigned j;
    placed = '0;
    j      = 0;
    for (int unsigned i = 0; i < SEC_W; i++) begin
      if (((i + 1) & i) != 0) begin
        placed[i] = in_data[j];
        j++;
      end
    end
  end

  always_comb begin
    par = '0;
    for (int unsigned k = 0; k < PU; k++) begin
      for (int unsigned i = 0; i < SEC_W; i++) begin
        if ((((i + 1) >> k) & 1) != 0) par[k] = par[k] ^ placed[i];
      end
    end
  end

  always_comb begin
    sec = placed;
    for (int unsigned k = 0; k < PU; k++) sec[(1 << k) - 1] = par[k];
  end

`ifdef HAM_SECDED_EN
  assign enc = {^sec, sec};
`else
  assign enc = sec;
`endif

  assign in_ready  = (occ != FULL);
  assign out_valid = (occ != EMPTY);
  assign out_code  = q0;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    occ_nxt = occ;
    case (occ)
      EMPTY:   if (push) occ_nxt = ONE;
      ONE:     if (push && !pop) occ_nxt = FULL;
               else if (pop && !push) occ_nxt = EMPTY;
      FULL:    if (pop) occ_nxt = ONE;
      default: occ_nxt = EMPTY;
    endcase
  end

  // With one entry, a simultaneous push/pop overwrites the head directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ <= EMPTY;
      q0  <= '0;
      q1  <= '0;
    end else begin
      occ <= occ_nxt;
      if (push && (occ == EMPTY || (occ == ONE && pop))) q0 <= enc;
      else if (push)                                     q1 <= enc;
      else if (pop && occ == FULL)                       q0 <= q1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        word_cnt <= '0;
    else if (cnt_clr)                  word_cnt <= '0;
    else if (pop && (word_cnt != '1))  word_cnt <= word_cnt + 1'b1;
  end

endmodule

// File: tb/tb_hamming_sec_stream_encoder.sv
// Directed and randomized bench for hamming_sec_stream_encoder against a queue-based reference model.
// Parity model uses the XOR-of-set-bit-positions formulation of Hamming codes.
module tb_hamming_sec_stream_encoder;

`ifdef HAM_SECDED_EN
  localparam int CW8  = 13;
  localparam int CW32 = 39;
  localparam int CW64 = 72;
`else
  localparam int CW8  = 12;
  localparam int CW32 = 38;
  localparam int CW64 = 71;
`endif
  localparam int WC_MAX = 15;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid, out_ready, cnt_clr;
  logic [7:0]      in_data;
  logic            in_ready, out_valid;
  logic [CW8-1:0]  out_code;
  logic [3:0]      word_cnt;

  logic            wv;
  logic [31:0]     d32;
  logic [63:0]     d64;
  logic            r32, v32, r64, v64;
  logic [CW32-1:0] c32;
  logic [CW64-1:0] c64;
  logic [15:0]     n32, n64;

  logic [127:0] mq[$];
  logic [127:0] q32[$];
  logic [127:0] q64[$];
  int wc;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hamming_sec_stream_encoder #(.DATA_W(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
    .cnt_clr(cnt_clr), .word_cnt(word_cnt)
  );

  hamming_sec_stream_encoder #(.DATA_W(32), .CNT_W(16)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(wv), .in_ready(r32), .in_data(d32),
    .out_valid(v32), .out_ready(1'b1), .out_code(c32),
    .cnt_clr(1'b0), .word_cnt(n32)
  );

  hamming_sec_stream_encoder #(.DATA_W(64), .CNT_W(16)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(wv), .in_ready(r64), .in_data(d64),
    .out_valid(v64), .out_ready(1'b1), .out_code(c64),
    .cnt_clr(1'b0), .word_cnt(n64)
  );

  // Check bits are the bits of the XOR of the positions of all set data bits.
  function automatic logic [127:0] ham(input logic [127:0] d, input int dw);
    int np, cw, pos, s;
    logic [127:0] c;
    np = 0;
    while ((1 << np) < dw + np + 1) np++;
    cw  = dw + np;
    c   = '0;
    pos = 1;
    s   = 0;
    for (int j = 0; j < dw; j++) begin
      while ((pos & (pos - 1)) == 0) pos++;
      if (d[j]) begin
        c[pos - 1] = 1'b1;
        s = s ^ pos;
      end
      pos++;
    end
    for (int k = 0; k < np; k++) c[(1 << k) - 1] = s[k];
`ifdef HAM_SECDED_EN
    c[cw] = ^c;
`endif
    return c;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: compare against the model before the edge, then advance the model.
  task automatic tick();
    logic push, pop, p32, p64;
    @(negedge clk);
    check("in_ready", in_ready, mq.size() != 2);
    check("out_valid", out_valid, mq.size() != 0);
    if (mq.size() != 0) check("out_code", out_code, mq[0]);
    check("word_cnt", word_cnt, wc);
    check("out_valid32", v32, q32.size() != 0);
    if (q32.size() != 0) check("out_code32", c32, q32[0]);
    check("out_valid64", v64, q64.size() != 0);
    if (q64.size() != 0) check("out_code64", c64, q64[0]);
    push = in_valid && (mq.size() != 2);
    pop  = (mq.size() != 0) && out_ready;
    p32  = wv && (q32.size() != 2);
    p64  = wv && (q64.size() != 2);
    @(posedge clk);
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(ham(in_data, 8));
    if (cnt_clr) wc = 0;
    else if (pop && wc != WC_MAX) wc++;
    if (q32.size() != 0) void'(q32.pop_front());
    if (p32) q32.push_back(ham(d32, 32));
    if (q64.size() != 0) void'(q64.pop_front());
    if (p64) q64.push_back(ham(d64, 64));
    #1;
    d32 = $urandom;
    d64 = {$urandom, $urandom};
  endtask

  logic [7:0]   kv_in  [4];
  logic [127:0] kv_out [4];

  initial begin
    kv_in[0] = 8'h00; kv_in[1] = 8'h01; kv_in[2] = 8'h80; kv_in[3] = 8'hFF;
`ifdef HAM_SECDED_EN
    kv_out[0] = 128'h0000; kv_out[1] = 128'h1007; kv_out[2] = 128'h1888; kv_out[3] = 128'h0F77;
`else
    kv_out[0] = 128'h000; kv_out[1] = 128'h007; kv_out[2] = 128'h888; kv_out[3] = 128'hF77;
`endif
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0; in_data = '0;
    wv = 1'b0; d32 = '0; d64 = '0; wc = 0;
    #3;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_code", out_code, '0);
    check("rst_word_cnt", word_cnt, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    wv = 1'b1;

    // Known vectors, one cycle latency from accept
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = kv_in[i];
      tick();
      check("kv_valid", out_valid, 1'b1);
      check("kv_code", out_code, kv_out[i]);
      in_valid = 1'b0;
      tick();
    end
    check("kv_count", word_cnt, 4);

    // Backpressure: third word held off while full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h11; tick();
    in_data   = 8'h22; tick();
    check("bp_full", in_ready, 1'b0);
    in_data   = 8'h33; tick(); tick();
    check("bp_head", out_code, ham(128'h11, 8));
    out_ready = 1'b1;
    tick(); tick();
    in_valid  = 1'b0;
    tick(); tick(); tick();

    // Streaming at one entry; counter saturates along the way
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_data = 8'($urandom);
      tick();
    end
    check("sat_count", word_cnt, WC_MAX);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_count", word_cnt, 0);
    tick(); tick();
    in_valid = 1'b0;
    tick();

    // Random handshakes with occasional clears
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cnt_clr   = ($urandom_range(0, 40) == 0);
      in_data   = 8'($urandom);
      tick();
    end
    cnt_clr = 1'b0;

    // Asynchronous reset with a full queue
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h5C; tick();
    in_data   = 8'hC5; tick();
    tick();
    wv = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_in_ready", in_ready, 1'b1);
    check("arst_word_cnt", word_cnt, '0);
    check("arst_out_code", out_code, '0);
    check("arst_out_valid32", v32, 1'b0);
    mq.delete(); q32.delete(); q64.delete(); wc = 0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    wv        = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    tick();
    check("post_rst_code", out_code, ham(128'hA5, 8));
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "simulation time limit exceeded");
  end

endmodule
